// File: rtl/multdiv_controller.sv
// multdiv_controller
// Sequences the shared iterative multiply/divide unit for the pipeline.
// It accepts one request at a time, issues the unit's start pulse, waits for
// a result or a timeout, and presents the writeback. Exceptions are remapped
// to the status register with an op-specific code.
module multdiv_controller #(
  parameter int          TIMEOUT       = 40,
  parameter logic [31:0] MULT_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE  = 32'd5,
  parameter logic [4:0]  STATUS_REG    = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] unit_operandA,
  output logic [31:0] unit_operandB,
  output logic        unit_ctrl_MULT,
  output logic        unit_ctrl_DIV,
  input  logic [31:0] unit_result,
  input  logic        unit_exception,
  input  logic        unit_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_WAIT = 6'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic        r_exc;
  logic [5:0]  r_waitCnt;

  // Control FSM: request latch, start, wait/timeout, writeback handshake.
  // The ready line is only sampled in WAIT so a stale ready left over from the
  // previous operation (or from a flushed one) can never complete this one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_rd      <= 5'd0;
      r_result  <= 32'd0;
      r_exc     <= 1'b0;
      r_waitCnt <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            r_op     <= req_op;
            r_a      <= req_a;
            r_b      <= req_b;
            r_rd     <= req_rd;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_waitCnt <= 6'd0;
          r_state   <= flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (unit_resultRDY) begin
            r_result <= unit_result;
            r_exc    <= unit_exception;
            r_state  <= S_DONE;
          end else if (r_waitCnt == LAST_WAIT) begin
            r_result <= 32'd0;
            r_exc    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 6'd1;
          end
        end
        S_DONE: begin
          if (flush || wb_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status, start pulses and writeback mapping decoded from the state and latches.
  // Flush gates the start pulse in the same cycle so a squashed op never starts.
  always_comb begin
    req_ready      = (r_state == S_IDLE);
    busy           = (r_state != S_IDLE);
    unit_ctrl_MULT = (r_state == S_START) && !flush && !r_op;
    unit_ctrl_DIV  = (r_state == S_START) && !flush &&  r_op;
    unit_operandA  = r_a;
    unit_operandB  = r_b;
    wb_valid       = (r_state == S_DONE);
    wb_rd          = r_rd;
    wb_data        = r_result;
    if (r_exc) begin
      wb_rd   = STATUS_REG;
      wb_data = r_op ? DIV_EXC_CODE : MULT_EXC_CODE;
    end
  end

endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller
// Directed bench for multdiv_controller: drives requests and plays the role of
// the multiply/divide unit by hand, comparing outputs to hand-computed values.
`timescale 1ns/1ps
module tb_multdiv_controller;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        busy;
  logic [31:0] unit_operandA;
  logic [31:0] unit_operandB;
  logic        unit_ctrl_MULT;
  logic        unit_ctrl_DIV;
  logic [31:0] unit_result;
  logic        unit_exception;
  logic        unit_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  int nCompared;
  int nMismatched;
  int cycleCount;

  multdiv_controller #(
    .TIMEOUT(40),
    .MULT_EXC_CODE(32'd4),
    .DIV_EXC_CODE(32'd5),
    .STATUS_REG(5'd30)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_rd(req_rd),
    .req_ready(req_ready),
    .busy(busy),
    .unit_operandA(unit_operandA),
    .unit_operandB(unit_operandB),
    .unit_ctrl_MULT(unit_ctrl_MULT),
    .unit_ctrl_DIV(unit_ctrl_DIV),
    .unit_result(unit_result),
    .unit_exception(unit_exception),
    .unit_resultRDY(unit_resultRDY),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .wb_ready(wb_ready)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stimulus changes and sampling both happen on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single rising edge; returns in the START cycle.
  task automatic applyStimulus(input logic op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    nCompared      = 0;
    nMismatched    = 0;
    reset          = 1'b0;
    flush          = 1'b0;
    req_valid      = 1'b0;
    req_op         = 1'b0;
    req_a          = 32'd0;
    req_b          = 32'd0;
    req_rd         = 5'd0;
    unit_result    = 32'd0;
    unit_exception = 1'b0;
    unit_resultRDY = 1'b0;
    wb_ready       = 1'b0;

    tick();
    tick();
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_opA", unit_operandA, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] MULT 7 * -3 with ready 17 cycles after the pulse");
    applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    checkOutput("mul_start_pulse", {31'd0, unit_ctrl_MULT}, 32'd1);
    checkOutput("mul_start_nodiv", {31'd0, unit_ctrl_DIV}, 32'd0);
    checkOutput("mul_start_busy", {31'd0, busy}, 32'd1);
    checkOutput("mul_start_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("mul_opA", unit_operandA, 32'd7);
    tick();
    checkOutput("mul_pulse_one_cycle", {31'd0, unit_ctrl_MULT}, 32'd0);
    for (int i = 0; i < 16; i++) tick();
    checkOutput("mul_wait_busy", {31'd0, busy}, 32'd1);
    checkOutput("mul_wait_no_wb", {31'd0, wb_valid}, 32'd0);
    unit_resultRDY = 1'b1;
    unit_result    = 32'hFFFF_FFEB;
    tick();
    unit_resultRDY = 1'b0;
    checkOutput("mul_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("mul_wb_rd", {27'd0, wb_rd}, 32'd5);
    checkOutput("mul_wb_data", wb_data, 32'hFFFF_FFEB);
    checkOutput("mul_done_busy", {31'd0, busy}, 32'd1);
    checkOutput("mul_opB_held", unit_operandB, 32'hFFFF_FFFD);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checkOutput("mul_back_idle", {31'd0, req_ready}, 32'd1);
    checkOutput("mul_idle_no_wb", {31'd0, wb_valid}, 32'd0);

    $display("[TB] async reset while waiting");
    applyStimulus(1'b1, 32'd100, 32'd3, 5'd8);
    tick();
    checkOutput("rstw_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rstw_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rstw_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    checkOutput("rstw_opA", unit_operandA, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rstw_req_ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] MULT exception, stale ready held during START");
    applyStimulus(1'b0, 32'h4000_0000, 32'd4, 5'd7);
    unit_resultRDY = 1'b1;
    unit_result    = 32'h0000_1234;
    unit_exception = 1'b0;
    tick();
    checkOutput("stale_rdy_ignored", {31'd0, wb_valid}, 32'd0);
    unit_exception = 1'b1;
    tick();
    unit_resultRDY = 1'b0;
    unit_exception = 1'b0;
    checkOutput("mulexc_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("mulexc_wb_rd", {27'd0, wb_rd}, 32'd30);
    checkOutput("mulexc_wb_data", wb_data, 32'd4);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    $display("[TB] DIV by zero with unit exception");
    applyStimulus(1'b1, 32'd5, 32'd0, 5'd9);
    checkOutput("div_start_pulse", {31'd0, unit_ctrl_DIV}, 32'd1);
    checkOutput("div_start_nomul", {31'd0, unit_ctrl_MULT}, 32'd0);
    tick();
    tick();
    unit_resultRDY = 1'b1;
    unit_exception = 1'b1;
    unit_result    = 32'hDEAD_BEEF;
    tick();
    unit_resultRDY = 1'b0;
    unit_exception = 1'b0;
    checkOutput("divexc_wb_rd", {27'd0, wb_rd}, 32'd30);
    checkOutput("divexc_wb_data", wb_data, 32'd5);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    $display("[TB] DIV timeout");
    applyStimulus(1'b1, 32'd77, 32'd7, 5'd12);
    cycleCount = 1;
    while (!wb_valid && cycleCount < 100) begin
      tick();
      cycleCount++;
    end
    checkOutput("timeout_latency", cycleCount, 32'd42);
    checkOutput("timeout_wb_rd", {27'd0, wb_rd}, 32'd30);
    checkOutput("timeout_wb_data", wb_data, 32'd5);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    $display("[TB] writeback backpressure with a queued request");
    applyStimulus(1'b0, 32'd11, 32'd5, 5'd3);
    tick();
    tick();
    unit_resultRDY = 1'b1;
    unit_result    = 32'h0000_0055;
    tick();
    unit_resultRDY = 1'b0;
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_a     = 32'd9;
    req_b     = 32'd2;
    req_rd    = 5'd4;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
      checkOutput("bp_wb_rd", {27'd0, wb_rd}, 32'd3);
      checkOutput("bp_wb_data", wb_data, 32'h0000_0055);
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checkOutput("bp_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("bp_idle_no_pulse", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("bp_queued_start", {31'd0, unit_ctrl_DIV}, 32'd1);
    checkOutput("bp_queued_opA", unit_operandA, 32'd9);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("bp_flush_idle", {31'd0, busy}, 32'd0);

    $display("[TB] flush on the third WAIT cycle");
    applyStimulus(1'b0, 32'd2, 32'd3, 5'd6);
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flw_busy", {31'd0, busy}, 32'd0);
    checkOutput("flw_wb_valid", {31'd0, wb_valid}, 32'd0);
    unit_resultRDY = 1'b1;
    unit_result    = 32'd6;
    tick();
    unit_resultRDY = 1'b0;
    tick();
    checkOutput("flw_late_rdy_busy", {31'd0, busy}, 32'd0);
    checkOutput("flw_late_rdy_wb", {31'd0, wb_valid}, 32'd0);

    $display("[TB] flush with a request in IDLE and flush in START");
    req_valid = 1'b1;
    req_op    = 1'b0;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("fli_busy", {31'd0, busy}, 32'd0);
    checkOutput("fli_no_pulse", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 32'd0);
    applyStimulus(1'b0, 32'd1, 32'd1, 5'd1);
    flush = 1'b1;
    #1;
    checkOutput("fls_pulse_blocked", {31'd0, unit_ctrl_MULT}, 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("fls_back_idle", {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/multdiv_controller.md
Name: multdiv_controller

Overview:
- Sequences the shared iterative multiply/divide unit on behalf of the processor pipeline.
- Accepts one MULT or DIV request at a time, latches its operands and destination register, and issues the unit's one-cycle start pulse.
- Holds the operands stable for the whole operation, waits for result-ready or a timeout, then presents a writeback with exception remapping to rstatus.
- Sits between decode/execute and the multdiv datapath; its busy output drives the pipeline stall.

Parameters:
- TIMEOUT, 40, max WAIT cycles before forcing a timeout exception (1..63).
- MULT_EXC_CODE, 4, value written to rstatus on a multiply exception.
- DIV_EXC_CODE, 5, value written to rstatus on a divide exception.
- STATUS_REG, 30, register index used for exception writeback.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; asserted while 0
- flush  in  1  abort any in-flight operation (branch/jump squash)
- req_valid  in  1  request present
- req_op  in  1  0 = MULT, 1 = DIV
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_rd  in  5  destination register
- req_ready  out  1  controller can accept a request (IDLE only)
- busy  out  1  high whenever state != IDLE; pipeline stall
- unit_operandA  out  32  latched operand A to the unit
- unit_operandB  out  32  latched operand B to the unit
- unit_ctrl_MULT  out  1  one-cycle multiply start pulse
- unit_ctrl_DIV  out  1  one-cycle divide start pulse
- unit_result  in  32  unit data_result
- unit_exception  in  1  unit data_exception
- unit_resultRDY  in  1  unit data_resultRDY
- wb_valid  out  1  writeback pending
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback data
- wb_ready  in  1  writeback accepted this cycle

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - All latched registers (op, a, b, rd, result, exc flag, wait counter) clear to 0.
  - Outputs: req_ready=1, busy=0, unit_ctrl_*=0, wb_valid=0, wb_rd=0, wb_data=0, unit_operandA/B=0.
- Reset mid-operation abandons the operation silently; no writeback is produced.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid & ~flush: latch op/a/b/rd, go to START.
  - req_valid together with flush: request dropped, stay in IDLE.
- START (exactly 1 cycle):
  - Assert unit_ctrl_MULT if op=0, unit_ctrl_DIV if op=1, never both.
  - Clear the wait counter, go to WAIT.
  - unit_resultRDY is ignored in START, because a stale ready from the previous operation may still be high.
- WAIT:
  - Counter increments each cycle, 6 bits, starting at 0.
  - unit_resultRDY=1: capture unit_result and unit_exception, go to DONE.
  - Else if counter == TIMEOUT-1: set the exception flag, capture 0 as the result, go to DONE.
  - If resultRDY arrives in the same cycle the timeout is reached, resultRDY wins.
- DONE:
  - wb_valid=1; outputs hold stable until accepted.
  - On wb_ready go to IDLE. The next request is accepted no earlier than the cycle after acceptance, i.e. no same-cycle turnaround.
- Writeback mapping:
  - Exception clear: wb_rd = latched rd, wb_data = captured result.
  - Exception set (unit exception or timeout): wb_rd = STATUS_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE according to the latched op.
  - Latched rd = 0 with no exception: wb_valid still asserts with wb_rd=0; the register file discards the write.
- Operands: unit_operandA/B are driven from the latch registers in every state. They change only on request acceptance, so they stay constant from START until the next accept.
- flush in START, WAIT or DONE:
  - Next state is IDLE, wb_valid drops the next cycle.
  - Start pulses are suppressed in that cycle. A flush in START prevents the pulse entirely.
  - The unit may keep running. Its later resultRDY is ignored, because only WAIT samples it and the next op re-pulses start.
- busy = (state != IDLE); combinational from state.
- Latency, accept to wb_valid: 1 (START) + N (WAIT cycles until resultRDY is seen, inclusive) + 1 cycle.

Test Plan:
1. Reset mid-WAIT: busy=1 in WAIT, then reset=0 → busy=0, wb_valid=0 and unit_ctrl_*=0 immediately (async); after release, req_ready=1.
2. MULT a=7, b=-3, rd=5; unit model raises RDY 17 cycles after the pulse with result 0xFFFFFFEB →
   - unit_ctrl_MULT high exactly one cycle.
   - wb_valid with wb_rd=5, wb_data=0xFFFFFFEB.
   - busy high from START through DONE.
3. MULT a=0x40000000, b=4; model returns exception=1 → wb_rd=30, wb_data=4. DIV by 0 with exception=1 → wb_rd=30, wb_data=5.
4. Timeout: DIV with model never asserting RDY, TIMEOUT=40 → wb_valid after exactly 1+40+1 cycles from accept; wb_rd=30, wb_data=5.
5. Writeback backpressure: result ready with wb_ready=0 for 5 cycles → wb_valid/rd/data held constant, req_ready=0. Raise wb_ready → IDLE next cycle, and a queued req_valid is accepted one cycle later.
6. Flush cases:
   - flush on the 3rd WAIT cycle → IDLE next cycle, no wb_valid, and a later RDY pulse is ignored.
   - flush with req_valid in IDLE → no START, no unit_ctrl pulse.
